rob_packet_assembler: RTL and testbench

Reassembles the 32-bit multi-beat packets from the Instruction Decoder (DecoderToRob1–4) and the Register Renaming Unit (RruToRob1–2) into one complete, wide Re-Order Buffer allocation entry. Sits directly upstream of the ROB allocation port and downstream of both packet producers. It buffers each producer's completed packets in order and joins them pairwise, checking that both halves carry the same ROB index.

---
 rtl/rob_packet_assembler.sv | 249 ++++++++++++++++++++++++
 tb/tb_rob_packet_assembler.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_packet_assembler.sv
// Joins four-beat decoder packets and two-beat RRU packets into one wide ROB
// allocation entry, buffering completed packets per side in small FIFOs.
module rob_packet_assembler #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [31:0] dec_data,
    input  logic        rru_valid,
    output logic        rru_ready,
    input  logic [31:0] rru_data,
    output logic        entry_valid,
    input  logic        entry_ready,
    output logic [6:0]  entry_rob_index,
    output logic        entry_is_branch,
    output logic        entry_branch_taken,
    output logic [4:0]  entry_dst_arch,
    output logic [7:0]  entry_op_id,
    output logic [31:0] entry_imm,
    output logic [63:0] entry_pc,
    output logic [7:0]  entry_dst_phy,
    output logic [7:0]  entry_src_phy1,
    output logic [7:0]  entry_src_phy2,
    output logic [7:0]  entry_prev_phy,
    output logic        err_mismatch
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int DEC_W = 118;
    localparam int RRU_W = 39;

    typedef enum logic [1:0] {D1, D2, D3, D4} dec_state_t;
    typedef enum logic       {R1, R2}         rru_state_t;

    dec_state_t        r_dec_state;
    dec_state_t        w_dec_next;
    rru_state_t        r_rru_state;
    rru_state_t        w_rru_next;

    logic [21:0]       r_dec_stage1;
    logic [31:0]       r_dec_stage2;
    logic [31:0]       r_dec_stage3;
    logic [30:0]       r_rru_stage1;

    logic [DEC_W-1:0]  r_dec_mem [DEPTH];
    logic [RRU_W-1:0]  r_rru_mem [DEPTH];
    logic [PW-1:0]     r_dec_wr;
    logic [PW-1:0]     r_dec_rd;
    logic [PW-1:0]     r_rru_wr;
    logic [PW-1:0]     r_rru_rd;

    logic              w_dec_full;
    logic              w_dec_empty;
    logic              w_rru_full;
    logic              w_rru_empty;
    logic              w_dec_acc;
    logic              w_rru_acc;
    logic              w_stage1_en;
    logic              w_stage2_en;
    logic              w_stage3_en;
    logic              w_dec_push;
    logic              w_rru_stage_en;
    logic              w_rru_push;
    logic              w_entry_valid;
    logic              w_pop;
    logic              w_rob_mismatch;
    logic [DEC_W-1:0]  w_dec_head;
    logic [RRU_W-1:0]  w_rru_head;
    logic              w_unused_rsvd;

    assign w_unused_rsvd = rru_data[24];

    // Full when the wrap bits differ but the slot indices match.
    assign w_dec_full  = (r_dec_wr[PW-1] != r_dec_rd[PW-1]) &&
                         (r_dec_wr[AW-1:0] == r_dec_rd[AW-1:0]);
    assign w_dec_empty = (r_dec_wr == r_dec_rd);
    assign w_rru_full  = (r_rru_wr[PW-1] != r_rru_rd[PW-1]) &&
                         (r_rru_wr[AW-1:0] == r_rru_rd[AW-1:0]);
    assign w_rru_empty = (r_rru_wr == r_rru_rd);

    assign dec_ready     = !flush && !w_dec_full;
    assign rru_ready     = !flush && !w_rru_full;
    assign w_dec_acc     = dec_valid && dec_ready;
    assign w_rru_acc     = rru_valid && rru_ready;
    assign w_entry_valid = !w_dec_empty && !w_rru_empty;
    assign w_pop         = w_entry_valid && entry_ready && !flush;
    assign entry_valid   = w_entry_valid;

    assign w_dec_head     = r_dec_mem[r_dec_rd[AW-1:0]];
    assign w_rru_head     = r_rru_mem[r_rru_rd[AW-1:0]];
    assign w_rob_mismatch = (w_dec_head[117:111] != w_rru_head[38:32]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dec_state <= D1;
        end else if (flush) begin
            r_dec_state <= D1;
        end else begin
            r_dec_state <= w_dec_next;
        end
    end

    always_comb begin
        w_dec_next = r_dec_state;
        if (w_dec_acc) begin
            unique case (r_dec_state)
                D1: w_dec_next = D2;
                D2: w_dec_next = D3;
                D3: w_dec_next = D4;
                D4: w_dec_next = D1;
            endcase
        end
    end

    always_comb begin
        w_stage1_en = w_dec_acc && (r_dec_state == D1);
        w_stage2_en = w_dec_acc && (r_dec_state == D2);
        w_stage3_en = w_dec_acc && (r_dec_state == D3);
        w_dec_push  = w_dec_acc && (r_dec_state == D4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rru_state <= R1;
        end else if (flush) begin
            r_rru_state <= R1;
        end else begin
            r_rru_state <= w_rru_next;
        end
    end

    always_comb begin
        w_rru_next = r_rru_state;
        if (w_rru_acc) begin
            unique case (r_rru_state)
                R1: w_rru_next = R2;
                R2: w_rru_next = R1;
            endcase
        end
    end

    always_comb begin
        w_rru_stage_en = w_rru_acc && (r_rru_state == R1);
        w_rru_push     = w_rru_acc && (r_rru_state == R2);
    end

    // Only the meaningful header fields are staged; reserved bits are dropped here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dec_stage1 <= '0;
            r_dec_stage2 <= '0;
            r_dec_stage3 <= '0;
            r_rru_stage1 <= '0;
        end else if (flush) begin
            r_dec_stage1 <= '0;
            r_dec_stage2 <= '0;
            r_dec_stage3 <= '0;
            r_rru_stage1 <= '0;
        end else begin
            if (w_stage1_en) begin
                r_dec_stage1 <= {dec_data[31:25], dec_data[22:21], dec_data[12:0]};
            end
            if (w_stage2_en) begin
                r_dec_stage2 <= dec_data;
            end
            if (w_stage3_en) begin
                r_dec_stage3 <= dec_data;
            end
            if (w_rru_stage_en) begin
                r_rru_stage1 <= {rru_data[31:25], rru_data[23:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_dec_push) begin
            r_dec_mem[r_dec_wr[AW-1:0]] <= {r_dec_stage1, r_dec_stage2, r_dec_stage3, dec_data};
        end
        if (w_rru_push) begin
            r_rru_mem[r_rru_wr[AW-1:0]] <= {r_rru_stage1, rru_data[7:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dec_wr <= '0;
            r_dec_rd <= '0;
            r_rru_wr <= '0;
            r_rru_rd <= '0;
        end else if (flush) begin
            r_dec_wr <= '0;
            r_dec_rd <= '0;
            r_rru_wr <= '0;
            r_rru_rd <= '0;
        end else begin
            if (w_dec_push) begin
                r_dec_wr <= r_dec_wr + PW'(1);
            end
            if (w_rru_push) begin
                r_rru_wr <= r_rru_wr + PW'(1);
            end
            if (w_pop) begin
                r_dec_rd <= r_dec_rd + PW'(1);
                r_rru_rd <= r_rru_rd + PW'(1);
            end
        end
    end

    // Sticky across flush; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_mismatch <= 1'b0;
        end else if (w_entry_valid && w_rob_mismatch) begin
            err_mismatch <= 1'b1;
        end
    end

    always_comb begin
        entry_rob_index    = '0;
        entry_is_branch    = 1'b0;
        entry_branch_taken = 1'b0;
        entry_dst_arch     = '0;
        entry_op_id        = '0;
        entry_imm          = '0;
        entry_pc           = '0;
        entry_dst_phy      = '0;
        entry_src_phy1     = '0;
        entry_src_phy2     = '0;
        entry_prev_phy     = '0;
        if (w_entry_valid) begin
            entry_rob_index    = w_dec_head[117:111];
            entry_is_branch    = w_dec_head[110];
            entry_branch_taken = w_dec_head[109];
            entry_dst_arch     = w_dec_head[108:104];
            entry_op_id        = w_dec_head[103:96];
            entry_imm          = w_dec_head[95:64];
            entry_pc           = w_dec_head[63:0];
            entry_dst_phy      = w_rru_head[31:24];
            entry_src_phy1     = w_rru_head[23:16];
            entry_src_phy2     = w_rru_head[15:8];
            entry_prev_phy     = w_rru_head[7:0];
        end
    end

endmodule

// File: tb/tb_rob_packet_assembler.sv
// Directed and randomized bench for rob_packet_assembler; expected entries come
// from per-side packet queues filled as whole packets are accepted.
module tb_rob_packet_assembler;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_data;
    logic        rru_valid;
    logic        rru_ready;
    logic [31:0] rru_data;
    logic        entry_valid;
    logic        entry_ready;
    logic [6:0]  entry_rob_index;
    logic        entry_is_branch;
    logic        entry_branch_taken;
    logic [4:0]  entry_dst_arch;
    logic [7:0]  entry_op_id;
    logic [31:0] entry_imm;
    logic [63:0] entry_pc;
    logic [7:0]  entry_dst_phy;
    logic [7:0]  entry_src_phy1;
    logic [7:0]  entry_src_phy2;
    logic [7:0]  entry_prev_phy;
    logic        err_mismatch;

    typedef struct packed {
        logic [6:0]  rob;
        logic        br;
        logic        tk;
        logic [4:0]  dst;
        logic [7:0]  op;
        logic [31:0] imm;
        logic [63:0] pc;
    } dec_pkt_t;

    typedef struct packed {
        logic [6:0] rob;
        logic [7:0] dst;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] prev;
    } rru_pkt_t;

    dec_pkt_t decQ[$];
    rru_pkt_t rruQ[$];
    int       total = 0;
    int       bad   = 0;
    logic     expErr = 1'b0;

    rob_packet_assembler #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_data(dec_data),
        .rru_valid(rru_valid), .rru_ready(rru_ready), .rru_data(rru_data),
        .entry_valid(entry_valid), .entry_ready(entry_ready),
        .entry_rob_index(entry_rob_index), .entry_is_branch(entry_is_branch),
        .entry_branch_taken(entry_branch_taken), .entry_dst_arch(entry_dst_arch),
        .entry_op_id(entry_op_id), .entry_imm(entry_imm), .entry_pc(entry_pc),
        .entry_dst_phy(entry_dst_phy), .entry_src_phy1(entry_src_phy1),
        .entry_src_phy2(entry_src_phy2), .entry_prev_phy(entry_prev_phy),
        .err_mismatch(err_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] decWord(input dec_pkt_t p, input int idx);
        logic [1:0] rsvA;
        logic [7:0] rsvB;
        rsvA = 2'($urandom);
        rsvB = 8'($urandom);
        case (idx)
            0:       return {p.rob, rsvA, p.br, p.tk, rsvB, p.dst, p.op};
            1:       return p.imm;
            2:       return p.pc[63:32];
            default: return p.pc[31:0];
        endcase
    endfunction

    function automatic logic [31:0] rruWord(input rru_pkt_t p, input int idx);
        logic        rsvA;
        logic [23:0] rsvB;
        rsvA = 1'($urandom);
        rsvB = 24'($urandom);
        if (idx == 0) return {p.rob, rsvA, p.dst, p.s1, p.s2};
        return {rsvB, p.prev};
    endfunction

    function automatic dec_pkt_t randDec(input logic [6:0] rob);
        dec_pkt_t p;
        p.rob = rob;
        p.br  = 1'($urandom);
        p.tk  = 1'($urandom);
        p.dst = 5'($urandom);
        p.op  = 8'($urandom);
        p.imm = $urandom;
        p.pc  = {$urandom, $urandom};
        return p;
    endfunction

    function automatic rru_pkt_t randRru(input logic [6:0] rob);
        rru_pkt_t p;
        p.rob  = rob;
        p.dst  = 8'($urandom);
        p.s1   = 8'($urandom);
        p.s2   = 8'($urandom);
        p.prev = 8'($urandom);
        return p;
    endfunction

    // Each beat is offered from just after a rising edge and taken on the next edge with ready high.
    task automatic decBeat(input logic [31:0] d, output bit ok);
        int n = 0;
        dec_valid = 1'b1;
        dec_data  = d;
        @(negedge clk);
        while (dec_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = (dec_ready === 1'b1);
        total++;
        assert (ok) else begin
            bad++;
            $error("FAIL dec_ready_wait observed=%b expected=1", dec_ready);
        end
        @(posedge clk);
        #1 dec_valid = 1'b0;
    endtask

    task automatic rruBeat(input logic [31:0] d, output bit ok);
        int n = 0;
        rru_valid = 1'b1;
        rru_data  = d;
        @(negedge clk);
        while (rru_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = (rru_ready === 1'b1);
        total++;
        assert (ok) else begin
            bad++;
            $error("FAIL rru_ready_wait observed=%b expected=1", rru_ready);
        end
        @(posedge clk);
        #1 rru_valid = 1'b0;
    endtask

    task automatic sendDec(input dec_pkt_t p);
        bit ok;
        bit allOk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            decBeat(decWord(p, i), ok);
            allOk &= ok;
        end
        if (allOk) decQ.push_back(p);
    endtask

    task automatic sendRru(input rru_pkt_t p);
        bit ok;
        bit allOk = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rruBeat(rruWord(p, i), ok);
            allOk &= ok;
        end
        if (allOk) rruQ.push_back(p);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits for the next entry, compares it with the oldest queued pair, then consumes it.
    task automatic checkEntry(input bit holdOnce);
        int       n = 0;
        dec_pkt_t d;
        rru_pkt_t r;
        @(negedge clk);
        while (entry_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("entry_valid_wait", entry_valid, 1'b1);
        if (decQ.size() == 0 || rruQ.size() == 0) begin
            total++;
            bad++;
            $error("FAIL model_pair observed=empty expected=pair");
            return;
        end
        d = decQ.pop_front();
        r = rruQ.pop_front();
        check("rob_index", entry_rob_index, d.rob);
        check("is_branch", entry_is_branch, d.br);
        check("taken", entry_branch_taken, d.tk);
        check("dst_arch", entry_dst_arch, d.dst);
        check("op_id", entry_op_id, d.op);
        check("imm", entry_imm, d.imm);
        check("pc", entry_pc, d.pc);
        check("dst_phy", entry_dst_phy, r.dst);
        check("src_phy1", entry_src_phy1, r.s1);
        check("src_phy2", entry_src_phy2, r.s2);
        check("prev_phy", entry_prev_phy, r.prev);
        if (holdOnce) begin
            @(negedge clk);
            check("hold_valid", entry_valid, 1'b1);
            check("hold_rob_index", entry_rob_index, d.rob);
            check("hold_pc", entry_pc, d.pc);
            check("hold_prev_phy", entry_prev_phy, r.prev);
        end
        entry_ready = 1'b1;
        @(posedge clk);
        #1 entry_ready = 1'b0;
        if (d.rob != r.rob) expErr = 1'b1;
        @(negedge clk);
        check("err_mismatch", err_mismatch, expErr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        dec_pkt_t dp[8];
        rru_pkt_t rp[8];
        dec_pkt_t a;
        rru_pkt_t ra;
        bit       ok;

        rst         = 1'b1;
        flush       = 1'b0;
        dec_valid   = 1'b0;
        dec_data    = '0;
        rru_valid   = 1'b0;
        rru_data    = '0;
        entry_ready = 1'b0;

        #1;
        check("rst_dec_ready", dec_ready, 1'b1);
        check("rst_rru_ready", rru_ready, 1'b1);
        check("rst_entry_valid", entry_valid, 1'b0);
        check("rst_err", err_mismatch, 1'b0);
        check("rst_rob_index", entry_rob_index, 7'd0);
        check("rst_pc", entry_pc, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] single instruction");
        a.rob = 7'd5; a.br = 1'b1; a.tk = 1'b0; a.dst = 5'd3; a.op = 8'h12;
        a.imm = 32'hDEADBEEF; a.pc = 64'h00000001_80000004;
        ra.rob = 7'd5; ra.dst = 8'h21; ra.s1 = 8'h22; ra.s2 = 8'h23; ra.prev = 8'h40;
        sendDec(a);
        check("single_no_rru_yet", entry_valid, 1'b0);
        sendRru(ra);
        check("single_latency", entry_valid, 1'b1);
        checkEntry(1'b1);

        $display("[TB] backpressure");
        for (int i = 0; i < 8; i++) begin
            dp[i] = randDec(7'(40 + i));
            rp[i] = randRru(7'(40 + i));
        end
        for (int i = 0; i < DEPTH; i++) begin
            check("bp_ready_before", dec_ready, 1'b1);
            sendDec(dp[i]);
        end
        check("bp_ready_full", dec_ready, 1'b0);
        check("bp_no_entry", entry_valid, 1'b0);
        fork
            sendDec(dp[DEPTH]);
            begin
                for (int i = 0; i <= DEPTH; i++) begin
                    sendRru(rp[i]);
                    checkEntry(1'b0);
                end
            end
        join

        $display("[TB] skewed arrival");
        dp[0] = randDec(7'd60); rp[0] = randRru(7'd60);
        dp[1] = randDec(7'd61); rp[1] = randRru(7'd61);
        sendRru(rp[0]);
        sendRru(rp[1]);
        idle(10);
        check("skew_no_entry", entry_valid, 1'b0);
        sendDec(dp[0]);
        check("skew_latency", entry_valid, 1'b1);
        sendDec(dp[1]);
        checkEntry(1'b0);
        checkEntry(1'b0);

        $display("[TB] flush mid-packet");
        sendDec(randDec(7'd20));
        sendRru(randRru(7'd20));
        @(negedge clk);
        check("flush_pre_valid", entry_valid, 1'b1);
        @(posedge clk);
        #1;
        a = randDec(7'd21);
        decBeat(decWord(a, 0), ok);
        decBeat(decWord(a, 1), ok);
        flush = 1'b1;
        @(negedge clk);
        check("flush_dec_ready", dec_ready, 1'b0);
        check("flush_rru_ready", rru_ready, 1'b0);
        @(posedge clk);
        #1 flush = 1'b0;
        decQ.delete();
        rruQ.delete();
        @(negedge clk);
        check("flush_entry_valid", entry_valid, 1'b0);
        check("flush_keeps_err", err_mismatch, expErr);
        @(posedge clk);
        #1;
        sendDec(randDec(7'd22));
        sendRru(randRru(7'd22));
        checkEntry(1'b0);

        $display("[TB] rob index mismatch");
        sendDec(randDec(7'd7));
        sendRru(randRru(7'd8));
        checkEntry(1'b0);
        sendDec(randDec(7'd9));
        sendRru(randRru(7'd9));
        checkEntry(1'b0);
        check("mismatch_sticky", err_mismatch, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 8; i++) begin
            logic [6:0] rob;
            rob   = 7'($urandom);
            dp[i] = randDec(rob);
            rp[i] = randRru(($urandom_range(3) == 0) ? rob + 7'd1 : rob);
        end
        fork
            for (int i = 0; i < 8; i++) begin
                idle($urandom_range(3));
                sendDec(dp[i]);
            end
            for (int j = 0; j < 8; j++) begin
                idle($urandom_range(6));
                sendRru(rp[j]);
            end
            for (int k = 0; k < 8; k++) begin
                idle($urandom_range(4));
                checkEntry(1'($urandom));
            end
        join

        $display("[TB] async reset mid-packet");
        sendDec(randDec(7'd30));
        sendRru(randRru(7'd31));
        a = randDec(7'd32);
        decBeat(decWord(a, 0), ok);
        decBeat(decWord(a, 1), ok);
        check("pre_rst_valid", entry_valid, 1'b1);
        check("pre_rst_err", err_mismatch, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_entry_valid", entry_valid, 1'b0);
        check("arst_err", err_mismatch, 1'b0);
        check("arst_dec_ready", dec_ready, 1'b1);
        check("arst_rru_ready", rru_ready, 1'b1);
        check("arst_rob_index", entry_rob_index, 7'd0);
        check("arst_dst_phy", entry_dst_phy, 8'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        decQ.delete();
        rruQ.delete();
        expErr = 1'b0;
        sendDec(randDec(7'd33));
        sendRru(randRru(7'd33));
        checkEntry(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
